ctrl_signal_gen: RTL and testbench

CTRL_SIGNAL_GEN -- requirements
Module: ctrl_signal_gen

---
 rtl/ctrl_signal_gen.sv | 167 ++++++++++++++++
 tb/tb_ctrl_signal_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_signal_gen.sv
// RV32I control-signal decoder with registered outputs (one-cycle latency).
// Define CTRL_SIGNAL_GEN_STRICT_DECODE_EN to turn reserved funct3/funct7 encodings into NOPs.
module ctrl_signal_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    output logic [3:0]  alu_cmd,
    output logic        alu_src,
    output logic        regfile_write_en,
    output logic [3:0]  regfile_write_width,
    output logic [1:0]  regfile_write_data,
    output logic        datamem_write_en,
    output logic [3:0]  datamem_write_width,
    output logic        add_4_pc
);

`ifdef CTRL_SIGNAL_GEN_STRICT_DECODE_EN
    localparam bit STRICT_DECODE = 1'b1;
`else
    localparam bit STRICT_DECODE = 1'b0;
`endif

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
        ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
        ALU_OR   = 4'd8, ALU_AND = 4'd9
    } alu_cmd_e;

    typedef enum logic [1:0] {
        RD_ALU = 2'd0, RD_LOAD = 2'd1, RD_PC4 = 2'd2, RD_UPPER = 2'd3
    } rd_src_e;

    typedef struct packed {
        alu_cmd_e    alu_cmd;
        logic        alu_src;
        logic        rf_we;
        logic [3:0]  rf_width;
        rd_src_e     rf_data;
        logic        dm_we;
        logic [3:0]  dm_width;
        logic        add_4_pc;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        alu_cmd: ALU_ADD, alu_src: 1'b0, rf_we: 1'b0, rf_width: 4'd4,
        rf_data: RD_ALU, dm_we: 1'b0, dm_width: 4'd4, add_4_pc: 1'b1
    };

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       funct7_ok;
    logic       reserved;
    ctrl_t      ctrl_d, ctrl_q;
    logic       unused_inst_bits;

    assign opcode    = inst[6:0];
    assign funct3    = inst[14:12];
    assign funct7    = inst[31:25];
    assign funct7_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);

    // Register indices and immediates are consumed downstream, not here.
    assign unused_inst_bits = ^{inst[24:15], inst[11:7]};

    function automatic alu_cmd_e arith_cmd(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  arith_cmd = alt ? ALU_SUB : ALU_ADD;
            3'b001:  arith_cmd = ALU_SLL;
            3'b010:  arith_cmd = ALU_SLT;
            3'b011:  arith_cmd = ALU_SLTU;
            3'b100:  arith_cmd = ALU_XOR;
            3'b101:  arith_cmd = alt ? ALU_SRA : ALU_SRL;
            3'b110:  arith_cmd = ALU_OR;
            default: arith_cmd = ALU_AND;
        endcase
    endfunction

    function automatic logic [3:0] access_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   access_bytes = 4'd1;
            2'b01:   access_bytes = 4'd2;
            default: access_bytes = 4'd4;
        endcase
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        ctrl_d   = CTRL_NOP;
        reserved = 1'b0;
        case (opcode)
            OPC_OP: begin
                ctrl_d.alu_cmd = arith_cmd(funct3, inst[30]);
                ctrl_d.rf_we   = 1'b1;
                reserved       = !funct7_ok;
            end
            OPC_OP_IMM: begin
                ctrl_d.alu_cmd = arith_cmd(funct3, inst[30] && (funct3 == 3'b101));
                ctrl_d.alu_src = 1'b1;
                ctrl_d.rf_we   = 1'b1;
                reserved       = (funct3[1:0] == 2'b01) && !funct7_ok;
            end
            OPC_LOAD: begin
                ctrl_d.alu_src  = 1'b1;
                ctrl_d.rf_we    = 1'b1;
                ctrl_d.rf_data  = RD_LOAD;
                ctrl_d.rf_width = access_bytes(funct3[1:0]);
                reserved        = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                ctrl_d.alu_src  = 1'b1;
                ctrl_d.dm_we    = 1'b1;
                ctrl_d.dm_width = access_bytes(funct3[1:0]);
                reserved        = (funct3 > 3'b010);
            end
            OPC_BRANCH: begin
                ctrl_d.alu_cmd  = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
                ctrl_d.add_4_pc = 1'b0;
                reserved        = (funct3[2:1] == 2'b01);
            end
            OPC_JAL, OPC_JALR: begin
                ctrl_d.alu_src  = 1'b1;
                ctrl_d.rf_we    = 1'b1;
                ctrl_d.rf_data  = RD_PC4;
                ctrl_d.add_4_pc = 1'b0;
                reserved        = (opcode == OPC_JALR) && (funct3 != 3'b000);
            end
            OPC_LUI, OPC_AUIPC: begin
                ctrl_d.alu_src = 1'b1;
                ctrl_d.rf_we   = 1'b1;
                ctrl_d.rf_data = RD_UPPER;
            end
            default: ctrl_d = CTRL_NOP;
        endcase
        if (STRICT_DECODE && reserved) begin
            ctrl_d = CTRL_NOP;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= CTRL_NOP;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign alu_cmd             = ctrl_q.alu_cmd;
    assign alu_src             = ctrl_q.alu_src;
    assign regfile_write_en    = ctrl_q.rf_we;
    assign regfile_write_width = ctrl_q.rf_width;
    assign regfile_write_data  = ctrl_q.rf_data;
    assign datamem_write_en    = ctrl_q.dm_we;
    assign datamem_write_width = ctrl_q.dm_width;
    assign add_4_pc            = ctrl_q.add_4_pc;

endmodule

// File: tb/tb_ctrl_signal_gen.sv
// Scoreboard bench for ctrl_signal_gen: directed RV32I words, async reset, random opcodes.
module tb_ctrl_signal_gen;

    logic        clk;
    logic        rst;
    logic [31:0] inst;
    logic [3:0]  alu_cmd;
    logic        alu_src;
    logic        regfile_write_en;
    logic [3:0]  regfile_write_width;
    logic [1:0]  regfile_write_data;
    logic        datamem_write_en;
    logic [3:0]  datamem_write_width;
    logic        add_4_pc;

    ctrl_signal_gen dut (
        .clk                 (clk),
        .rst                 (rst),
        .inst                (inst),
        .alu_cmd             (alu_cmd),
        .alu_src             (alu_src),
        .regfile_write_en    (regfile_write_en),
        .regfile_write_width (regfile_write_width),
        .regfile_write_data  (regfile_write_data),
        .datamem_write_en    (datamem_write_en),
        .datamem_write_width (datamem_write_width),
        .add_4_pc            (add_4_pc)
    );

    typedef struct packed {
        logic [3:0] cmd;
        logic       src;
        logic       rwe;
        logic [3:0] rw;
        logic [1:0] rd;
        logic       dwe;
        logic [3:0] dw;
        logic       pc4;
    } exp_t;

    typedef struct {
        string name;
        exp_t  e;
    } sb_entry_t;

    localparam exp_t NOP = '{cmd: 4'd0, src: 1'b0, rwe: 1'b0, rw: 4'd4, rd: 2'd0,
                             dwe: 1'b0, dw: 4'd4, pc4: 1'b1};

    sb_entry_t sb_q[$];
    int        n_checks = 0;
    int        n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input int cmd, input int src, input int rwe, input int rw,
                                input int rd, input int dwe, input int dw, input int pc4);
        exp_t e;
        e.cmd = 4'(cmd); e.src = 1'(src); e.rwe = 1'(rwe); e.rw = 4'(rw);
        e.rd  = 2'(rd);  e.dwe = 1'(dwe); e.dw  = 4'(dw);  e.pc4 = 1'(pc4);
        return e;
    endfunction

    // Reference decode, table-driven for the arithmetic group.
    function automatic exp_t model(input logic [31:0] i);
        int   base_cmd [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int   f3 = int'(i[14:12]);
        int   f7 = int'(i[31:25]);
        int   nbytes;
        bit   f7_bad = (f7 != 0) && (f7 != 32);
        bit   bad = 1'b0;
        exp_t e = NOP;
        nbytes = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        case (i[6:0])
            7'h33: begin
                e = mk(base_cmd[f3] + ((i[30] && (f3 == 0 || f3 == 5)) ? 1 : 0), 0, 1, 4, 0, 0, 4, 1);
                bad = f7_bad;
            end
            7'h13: begin
                e = mk(base_cmd[f3] + ((i[30] && f3 == 5) ? 1 : 0), 1, 1, 4, 0, 0, 4, 1);
                bad = (f3 == 1 || f3 == 5) && f7_bad;
            end
            7'h03: begin e = mk(0, 1, 1, nbytes, 1, 0, 4, 1); bad = (f3 == 3 || f3 >= 6); end
            7'h23: begin e = mk(0, 1, 0, 4, 0, 1, nbytes, 1); bad = (f3 > 2); end
            7'h63: begin
                e = mk((f3 < 4) ? 1 : (f3 < 6) ? 3 : 4, 0, 0, 4, 0, 0, 4, 0);
                bad = (f3 == 2 || f3 == 3);
            end
            7'h6F: e = mk(0, 1, 1, 4, 2, 0, 4, 0);
            7'h67: begin e = mk(0, 1, 1, 4, 2, 0, 4, 0); bad = (f3 != 0); end
            7'h37, 7'h17: e = mk(0, 1, 1, 4, 3, 0, 4, 1);
            default: e = NOP;
        endcase
`ifdef CTRL_SIGNAL_GEN_STRICT_DECODE_EN
        if (bad) e = NOP;
`else
        if (bad) e = e;
`endif
        return e;
    endfunction

    task automatic push(input string name, input exp_t e);
        sb_entry_t s;
        s.name = name;
        s.e    = e;
        sb_q.push_back(s);
    endtask

    task automatic compare_outputs();
        sb_entry_t s;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        s = sb_q.pop_front();
        check({s.name, ".alu_cmd"},             32'(alu_cmd),             32'(s.e.cmd));
        check({s.name, ".alu_src"},             32'(alu_src),             32'(s.e.src));
        check({s.name, ".regfile_write_en"},    32'(regfile_write_en),    32'(s.e.rwe));
        check({s.name, ".regfile_write_width"}, 32'(regfile_write_width), 32'(s.e.rw));
        check({s.name, ".regfile_write_data"},  32'(regfile_write_data),  32'(s.e.rd));
        check({s.name, ".datamem_write_en"},    32'(datamem_write_en),    32'(s.e.dwe));
        check({s.name, ".datamem_write_width"}, 32'(datamem_write_width), 32'(s.e.dw));
        check({s.name, ".add_4_pc"},            32'(add_4_pc),            32'(s.e.pc4));
    endtask

    // Drive one word, expect its decode after the next rising edge.
    task automatic run_inst(input string name, input logic [31:0] w, input exp_t e);
        inst = w;
        push(name, e);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    initial begin
        logic [6:0]  opcs [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                   7'h67, 7'h37, 7'h17, 7'h0F, 7'h73, 7'h7F};
        logic [31:0] r;
        logic [31:0] w;

        rst  = 1'b0;
        inst = 32'h0015_2023;
        #1 rst = 1'b1;
        #2;
        push("reset_async", NOP);
        compare_outputs();
        @(posedge clk);
        #1;
        push("reset_hold", NOP);
        compare_outputs();

        @(negedge clk);
        rst = 1'b0;
        run_inst("first_after_reset_sw", 32'h0015_2023, mk(0, 1, 0, 4, 0, 1, 4, 1));
        run_inst("sub",   32'h4031_00B3, mk(1, 0, 1, 4, 0, 0, 4, 1));
        run_inst("add",   32'h0020_81B3, mk(0, 0, 1, 4, 0, 0, 4, 1));
        run_inst("sra",   32'h4031_50B3, mk(7, 0, 1, 4, 0, 0, 4, 1));
        run_inst("and",   32'h0020_F0B3, mk(9, 0, 1, 4, 0, 0, 4, 1));
        run_inst("srai",  32'h4030_D093, mk(7, 1, 1, 4, 0, 0, 4, 1));
        run_inst("addi_b30", 32'h4000_0093, mk(0, 1, 1, 4, 0, 0, 4, 1));
        run_inst("lbu",   32'h0033_4283, mk(0, 1, 1, 1, 1, 0, 4, 1));
        run_inst("lh",    32'h0000_1083, mk(0, 1, 1, 2, 1, 0, 4, 1));
        run_inst("sb",    32'h0010_0023, mk(0, 1, 0, 4, 0, 1, 1, 1));
        run_inst("sh",    32'h0010_1023, mk(0, 1, 0, 4, 0, 1, 2, 1));
        run_inst("beq",   32'h0000_0063, mk(1, 0, 0, 4, 0, 0, 4, 0));
        run_inst("blt",   32'h0000_4063, mk(3, 0, 0, 4, 0, 0, 4, 0));
        run_inst("bgeu",  32'h0000_7063, mk(4, 0, 0, 4, 0, 0, 4, 0));
        run_inst("jal",   32'h0000_00EF, mk(0, 1, 1, 4, 2, 0, 4, 0));
        run_inst("jalr",  32'h0000_8067, mk(0, 1, 1, 4, 2, 0, 4, 0));
        run_inst("lui",   32'h0000_10B7, mk(0, 1, 1, 4, 3, 0, 4, 1));
        run_inst("auipc", 32'h0000_1097, mk(0, 1, 1, 4, 3, 0, 4, 1));
        run_inst("fence", 32'h0000_000F, NOP);
        run_inst("ecall", 32'h0000_0073, NOP);
`ifdef CTRL_SIGNAL_GEN_STRICT_DECODE_EN
        run_inst("load_f3_011", 32'h0005_3083, NOP);
        run_inst("sub_bad_f7",  32'h0231_00B3, NOP);
`else
        run_inst("load_f3_011", 32'h0005_3083, mk(0, 1, 1, 4, 1, 0, 4, 1));
        run_inst("sub_bad_f7",  32'h0231_00B3, mk(0, 0, 1, 4, 0, 0, 4, 1));
`endif

        // Async reset between edges right after a store.
        run_inst("store_before_rst", 32'h0015_2023, mk(0, 1, 0, 4, 0, 1, 4, 1));
        #2 rst = 1'b1;
        #1;
        push("rst_midcycle", NOP);
        compare_outputs();
        @(negedge clk);
        rst = 1'b0;
        run_inst("after_midcycle_rst_lbu", 32'h0033_4283, mk(0, 1, 1, 1, 1, 0, 4, 1));

        for (int k = 0; k < 200; k++) begin
            r = $urandom();
            w = {r[31:7], opcs[$urandom_range(0, 11)]};
            run_inst($sformatf("rand%0d_%08h", k, w), w, model(w));
        end

        if (sb_q.size() != 0) check("scoreboard_leftover", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
